// File: rtl/resultado_bcd.sv
// Sign plus three-digit BCD conversion of a 9-bit two's-complement result, via a fixed 11-clock double dabble.
// Optional leading-zero blanking (digit 4'hF) is enabled with `RESULTADO_BCD_BLANK_EN.
module resultado_bcd (
  input  logic              relogio,
  input  logic              reset,
  input  logic signed [8:0] valor,
  input  logic              inicio,
  output logic              ocupado,
  output logic              pronto,
  output logic              sinal,
  output logic [3:0]        centenas,
  output logic [3:0]        dezenas,
  output logic [3:0]        unidades
);

  typedef enum logic [1:0] {IDLE, NEG, SHIFT, DONE} estado_t;

  estado_t           estado_q;
  logic signed [8:0] valor_q;
  logic        [8:0] mag_q;
  logic       [11:0] bcd_q;
  logic        [3:0] cnt_q;
  logic              sinal_int_q;

  logic       [11:0] bcd_adj_d;
  logic       [20:0] shift_d;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // -256 negates to 9'h100, which read unsigned is exactly 256
  function automatic logic [8:0] magnitude(input logic signed [8:0] v);
    return $unsigned(v[8] ? (~v + 9'sd1) : v);
  endfunction

  always_comb begin
    bcd_adj_d = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    shift_d   = {bcd_adj_d, mag_q} << 1;
  end

  always_ff @(posedge relogio) begin
    if (reset) begin
      estado_q <= IDLE;
      cnt_q    <= 4'd0;
      ocupado  <= 1'b0;
      pronto   <= 1'b0;
      sinal    <= 1'b0;
      centenas <= 4'd0;
      dezenas  <= 4'd0;
      unidades <= 4'd0;
    end else begin
      case (estado_q)
        IDLE: begin
          pronto <= 1'b0;
          if (inicio) begin
            valor_q  <= valor;
            ocupado  <= 1'b1;
            estado_q <= NEG;
          end else begin
            ocupado <= 1'b0;
          end
        end
        NEG: begin
          sinal_int_q <= valor_q[8];
          mag_q       <= magnitude(valor_q);
          bcd_q       <= 12'd0;
          cnt_q       <= 4'd0;
          estado_q    <= SHIFT;
        end
        SHIFT: begin
          bcd_q <= shift_d[20:9];
          mag_q <= shift_d[8:0];
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd8) estado_q <= DONE;
        end
        DONE: begin
          // ocupado stays high through the pronto cycle and drops with it in IDLE
          sinal    <= sinal_int_q;
          unidades <= bcd_q[3:0];
`ifdef RESULTADO_BCD_BLANK_EN
          centenas <= (bcd_q[11:8] == 4'd0) ? 4'hF : bcd_q[11:8];
          dezenas  <= (bcd_q[11:4] == 8'd0) ? 4'hF : bcd_q[7:4];
`else
          centenas <= bcd_q[11:8];
          dezenas  <= bcd_q[7:4];
`endif
          pronto   <= 1'b1;
          estado_q <= IDLE;
        end
        default: estado_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_resultado_bcd.sv
// Directed bench for resultado_bcd: reset, conversions, ignored request, abort, back-to-back.
module tb_resultado_bcd;

  logic              relogio = 1'b0;
  logic              reset   = 1'b1;
  logic signed [8:0] valor   = 9'sd0;
  logic              inicio  = 1'b0;
  logic              ocupado, pronto, sinal;
  logic        [3:0] centenas, dezenas, unidades;

  int n_cmp = 0;
  int n_err = 0;

  resultado_bcd dut (
    .relogio (relogio),
    .reset   (reset),
    .valor   (valor),
    .inicio  (inicio),
    .ocupado (ocupado),
    .pronto  (pronto),
    .sinal   (sinal),
    .centenas(centenas),
    .dezenas (dezenas),
    .unidades(unidades)
  );

  always #5 relogio = ~relogio;

  task automatic tick();
    @(posedge relogio);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] disp(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u);
`ifdef RESULTADO_BCD_BLANK_EN
    return {(c == 4'd0) ? 4'hF : c, (c == 4'd0 && d == 4'd0) ? 4'hF : d, u};
`else
    return {c, d, u};
`endif
  endfunction

  task automatic check_res(input string tag, input logic s,
                           input logic [3:0] c, input logic [3:0] d, input logic [3:0] u);
    chk({tag, "_sinal"}, 32'(sinal), 32'(s));
    chk({tag, "_digits"}, 32'({centenas, dezenas, unidades}), 32'(disp(c, d, u)));
  endtask

  task automatic start(input logic [8:0] v);
    valor  = v;
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    chk("ocupado_after_accept", 32'(ocupado), 32'd1);
  endtask

  // n = edges already elapsed since the accepting edge
  task automatic wait_pronto(input int already, input string tag);
    int n = already;
    while (pronto !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd11);
    chk({tag, "_ocupado_in_pronto"}, 32'(ocupado), 32'd1);
  endtask

  task automatic back_to_idle(input string tag);
    tick();
    chk({tag, "_pronto_single"}, 32'(pronto), 32'd0);
    chk({tag, "_ocupado_fall"}, 32'(ocupado), 32'd0);
  endtask

  initial begin
    int pulses;

    // reset held two clocks, then idle with inicio low
    reset = 1'b1;
    tick();
    tick();
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_pronto", 32'(pronto), 32'd0);
    chk("rst_sinal", 32'(sinal), 32'd0);
    chk("rst_digits", 32'({centenas, dezenas, unidades}), 32'h000);
    reset = 1'b0;
    tick();
    tick();
    tick();
    chk("idle_ocupado", 32'(ocupado), 32'd0);
    chk("idle_pronto", 32'(pronto), 32'd0);
    chk("idle_digits", 32'({sinal, centenas, dezenas, unidades}), 32'h0000);

    // +255
    start(9'h0FF);
    wait_pronto(0, "p255");
    check_res("p255", 1'b0, 4'd2, 4'd5, 4'd5);
    back_to_idle("p255");

    // -256, followed back-to-back by -10 accepted during the pronto cycle
    start(9'h100);
    wait_pronto(0, "m256");
    check_res("m256", 1'b1, 4'd2, 4'd5, 4'd6);
    valor  = 9'h1F6;
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    chk("b2b_pronto_low", 32'(pronto), 32'd0);
    chk("b2b_ocupado", 32'(ocupado), 32'd1);
    check_res("m256_hold", 1'b1, 4'd2, 4'd5, 4'd6);
    wait_pronto(0, "m10");
    check_res("m10", 1'b1, 4'd0, 4'd1, 4'd0);
    back_to_idle("m10");

    // 123 with a second request 3 clocks later that must be ignored
    start(9'h07B);
    tick();
    tick();
    tick();
    valor  = 9'h001;
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    wait_pronto(4, "p123");
    check_res("p123", 1'b0, 4'd1, 4'd2, 4'd3);
    back_to_idle("p123");
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (pronto === 1'b1) pulses++;
    end
    chk("p123_no_queued_pronto", 32'(pulses), 32'd0);
    check_res("p123_hold", 1'b0, 4'd1, 4'd2, 4'd3);

    // zero
    start(9'h000);
    wait_pronto(0, "zero");
    check_res("zero", 1'b0, 4'd0, 4'd0, 4'd0);
    back_to_idle("zero");

    // load nonzero outputs, then abort a conversion with reset 5 clocks after acceptance
    start(9'h0FF);
    wait_pronto(0, "p255b");
    check_res("p255b", 1'b0, 4'd2, 4'd5, 4'd5);
    back_to_idle("p255b");
    start(9'h0FF);
    tick();
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_ocupado", 32'(ocupado), 32'd0);
    chk("abort_pronto", 32'(pronto), 32'd0);
    chk("abort_outputs", 32'({sinal, centenas, dezenas, unidades}), 32'h0000);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (pronto === 1'b1 || ocupado === 1'b1) pulses++;
    end
    chk("abort_no_activity", 32'(pulses), 32'd0);

    // -1 after the abort
    start(9'h1FF);
    wait_pronto(0, "m1");
    check_res("m1", 1'b1, 4'd0, 4'd0, 4'd1);
    back_to_idle("m1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
